tc_pl_cap_data: RTL and testbench
=================================

TC_PL_CAP_DATA -- requirements
Module: tc_pl_cap_data

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning ADC sample width.
REQ-002 SHALL have parameter GAIN_W, default 1, meaning gain tag width; it matches gain_value of the capture controller.
REQ-003 SHALL have parameter ADDR_W, default 10, meaning buffer depth 2^ADDR_W samples.
REQ-004 SHALL have parameter LEN_W, default 16, meaning sample_len width.
REQ-005 SHALL have port clk125, input, 1 bit, the single clock for all logic.
REQ-006 SHALL have port rst_n, input, 1 bit; reset is synchronous and active-low.
REQ-007 SHALL have port data_en, input, 1 bit, level request from the capture controller to capture one gain segment.
REQ-008 SHALL have port data_cmpt, output, 1 bit, one-cycle pulse when the segment is fully delivered downstream.
REQ-009 SHALL have port gain_value, input, GAIN_W bits, current gain index.
REQ-010 SHALL have port sample_len, input, LEN_W bits, samples per segment.
REQ-011 SHALL have port adc_data, input, DATA_W bits, ADC sample.
REQ-012 SHALL have port adc_valid, input, 1 bit, adc_data qualifier.
REQ-013 SHALL have port out_data, output, GAIN_W+DATA_W bits, {gain tag, sample}.
REQ-014 SHALL have port out_valid, output, 1 bit, out_data qualifier.
REQ-015 SHALL have port out_ready, input, 1 bit, downstream accept.
REQ-016 SHALL have port out_last, output, 1 bit, marks the final word of a segment.
REQ-017 SHALL have port ovf_cnt, output, 16 bits, count of segments whose sample_len was clamped; saturates at 0xFFFF.

Function
REQ-018 SHALL implement states IDLE, CAPT, DRAIN, DONE, WAITLOW.
REQ-019 IDLE: on data_en=1, SHALL latch gain_value and len=min(sample_len, 2^ADDR_W), clear write address, and go to CAPT.
REQ-020 When sample_len > 2^ADDR_W, SHALL clamp len and increment ovf_cnt once.
REQ-021 When the latched len is 0, SHALL go directly to DONE with no output words.
REQ-022 CAPT: each cycle with adc_valid=1 SHALL write adc_data to the buffer and advance the write address; adc_valid=0 cycles SHALL be skipped.
REQ-023 CAPT SHALL go to DRAIN on the cycle the len-th sample is written.
REQ-024 DRAIN SHALL read the buffer in write order with 1-cycle RAM latency through one output register.
REQ-025 out_valid SHALL rise no later than 2 cycles after DRAIN entry.
REQ-026 While out_valid=1 and out_ready=0, out_data, out_valid and out_last SHALL hold stable.
REQ-027 On out_valid&out_ready, SHALL present the next word on the next cycle; back-to-back transfers at full rate are required.
REQ-028 out_last SHALL be 1 only on word len; out_data[top GAIN_W bits] SHALL be the gain latched in IDLE.
REQ-029 After the last-word handshake, SHALL enter DONE.
REQ-030 DONE SHALL assert data_cmpt for exactly one cycle, then go to WAITLOW.
REQ-031 WAITLOW SHALL return to IDLE when data_en=0; a level-held data_en SHALL never restart a segment.
REQ-032 If data_en falls in CAPT or DRAIN, SHALL abort: drop out_valid next cycle, discard remaining words, issue no data_cmpt, and return to IDLE.
REQ-033 adc_valid outside CAPT SHALL be ignored.

Reset
REQ-034 While rst_n=0 at a clk125 edge, SHALL set state IDLE, data_cmpt=0, out_valid=0, out_last=0, out_data=0, ovf_cnt=0, and clear addresses and latched len/gain.
REQ-035 Reset mid-segment SHALL discard the segment; buffer contents need not be cleared.

Structure
REQ-036 Shared package tc_pl_cap_pkg SHALL hold state encodings and default widths (DATA_W, GAIN_W, ADDR_W, LEN_W).
REQ-037 Buffer SHALL be a sub-module tc_pl_cap_ram: simple dual-port, registered read, one write and one read port on clk125.

Verification
REQ-038 len=4, gain=1, adc_valid continuous 0x0011..0x0014, out_ready=1 -> out_data 0x10011..0x10014, out_last on the 4th word, one data_cmpt pulse.
REQ-039 len=8, adc_valid toggling every cycle -> exactly 8 samples captured, gaps skipped, order preserved.
REQ-040 len=4, out_ready low for 3 cycles on word 2 -> word 2 held stable, no loss or duplication, data_cmpt only after word 4.
REQ-041 sample_len=2000 with ADDR_W=10 -> 1024 words output, ovf_cnt=1.
REQ-042 data_en dropped on the 3rd capture cycle -> no out_valid, no data_cmpt; the next data_en rise runs a clean segment.
REQ-043 sample_len=0 -> data_cmpt one cycle after data_en rise, zero words; rst_n=0 mid-DRAIN -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/tc_pl_cap_pkg.sv
`default_nettype none
// +--------------------------------------------------------------+
// | tc_pl_cap_pkg : shared widths and FSM encodings   rev 1.0    |
// +--------------------------------------------------------------+
package tc_pl_cap_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_GAIN_W = 1;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_LEN_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPT    = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_DONE    = 3'd3,
    ST_WAITLOW = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/tc_pl_cap_ram.sv
`default_nettype none
// +--------------------------------------------------------------+
// | tc_pl_cap_ram : simple dual-port buffer, registered read     |
// | rev 1.0                                                      |
// +--------------------------------------------------------------+
module tc_pl_cap_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk125,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk125) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read data holds while i_re is low so a stalled word is never lost.
  always_ff @(posedge clk125) begin
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/tc_pl_cap_data.sv
`default_nettype none
// +--------------------------------------------------------------+
// | tc_pl_cap_data : capture one gain segment, replay it tagged  |
// | rev 1.0                                                      |
// +--------------------------------------------------------------+
module tc_pl_cap_data
  import tc_pl_cap_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int GAIN_W = DEF_GAIN_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic                     clk125,
  input  logic                     rst_n,
  input  logic                     data_en,
  output logic                     data_cmpt,
  input  logic [GAIN_W-1:0]        gain_value,
  input  logic [LEN_W-1:0]         sample_len,
  input  logic [DATA_W-1:0]        adc_data,
  input  logic                     adc_valid,
  output logic [GAIN_W+DATA_W-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [15:0]              ovf_cnt
);

  localparam int CW = (LEN_W > ADDR_W + 1) ? LEN_W : ADDR_W + 1;
  localparam logic [ADDR_W:0] C_DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] C_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t                     r_state;
  logic [GAIN_W-1:0]          r_gain;
  logic [ADDR_W:0]            r_len;
  logic [ADDR_W:0]            r_wcnt;
  logic [ADDR_W:0]            r_rcnt;
  logic                       r_rvalid;
  logic                       r_rlast;
  logic                       r_ovalid;
  logic                       r_olast;
  logic [GAIN_W+DATA_W-1:0]   r_odata;
  logic                       r_cmpt;
  logic [15:0]                r_ovf;

  logic [CW-1:0]              w_slen;
  logic                       w_clamp;
  logic [ADDR_W:0]            w_len;
  logic                       w_we;
  logic                       w_rd;
  logic                       w_load;
  logic [DATA_W-1:0]          w_rdata;

  assign w_slen  = CW'(sample_len);
  assign w_clamp = w_slen > CW'(C_DEPTH);
  assign w_len   = w_clamp ? C_DEPTH : (ADDR_W + 1)'(w_slen);
  assign w_we    = (r_state == ST_CAPT) && data_en && adc_valid;

  // Two-stage pipe: RAM read register feeds the output register, each
  // advancing only when the stage ahead is free, giving full-rate drain.
  assign w_load = r_rvalid && (!r_ovalid || out_ready);
  assign w_rd   = (r_state == ST_DRAIN) && data_en && (r_rcnt != r_len)
                && (!r_rvalid || w_load);

  tc_pl_cap_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk125  (clk125),
    .i_we    (w_we),
    .i_waddr (r_wcnt[ADDR_W-1:0]),
    .i_wdata (adc_data),
    .i_re    (w_rd),
    .i_raddr (r_rcnt[ADDR_W-1:0]),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk125) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_gain   <= '0;
      r_len    <= '0;
      r_wcnt   <= '0;
      r_rcnt   <= '0;
      r_rvalid <= 1'b0;
      r_rlast  <= 1'b0;
      r_ovalid <= 1'b0;
      r_olast  <= 1'b0;
      r_odata  <= '0;
      r_cmpt   <= 1'b0;
      r_ovf    <= '0;
    end else begin
      r_cmpt <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (data_en) begin
            r_gain <= gain_value;
            r_len  <= w_len;
            r_wcnt <= '0;
            r_rcnt <= '0;
            if (w_clamp && (r_ovf != 16'hFFFF)) r_ovf <= r_ovf + 16'd1;
            if (w_len == '0) begin
              r_state <= ST_DONE;
              r_cmpt  <= 1'b1;
            end else begin
              r_state <= ST_CAPT;
            end
          end
        end
        ST_CAPT: begin
          if (!data_en) begin
            r_state <= ST_IDLE;
          end else if (adc_valid) begin
            r_wcnt <= r_wcnt + C_ONE;
            if ((r_wcnt + C_ONE) == r_len) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!data_en) begin
            r_state  <= ST_IDLE;
            r_rvalid <= 1'b0;
            r_ovalid <= 1'b0;
            r_olast  <= 1'b0;
          end else begin
            if (w_rd) begin
              r_rcnt   <= r_rcnt + C_ONE;
              r_rlast  <= (r_rcnt + C_ONE) == r_len;
              r_rvalid <= 1'b1;
            end else if (w_load) begin
              r_rvalid <= 1'b0;
            end
            if (w_load) begin
              r_ovalid <= 1'b1;
              r_olast  <= r_rlast;
              r_odata  <= {r_gain, w_rdata};
            end else if (r_ovalid && out_ready) begin
              r_ovalid <= 1'b0;
              r_olast  <= 1'b0;
            end
            if (r_ovalid && out_ready && r_olast) begin
              r_state  <= ST_DONE;
              r_ovalid <= 1'b0;
              r_olast  <= 1'b0;
              r_cmpt   <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_WAITLOW;
        end
        ST_WAITLOW: begin
          if (!data_en) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign data_cmpt = r_cmpt;
  assign out_data  = r_odata;
  assign out_valid = r_ovalid;
  assign out_last  = r_olast;
  assign ovf_cnt   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_tc_pl_cap_data.sv
`default_nettype none
// +--------------------------------------------------------------+
// | tb_tc_pl_cap_data : directed bench for tc_pl_cap_data        |
// | rev 1.0                                                      |
// +--------------------------------------------------------------+
module tb_tc_pl_cap_data;

  logic        clk125 = 1'b0;
  logic        rst_n;
  logic        data_en;
  logic        data_cmpt;
  logic [0:0]  gain_value;
  logic [15:0] sample_len;
  logic [15:0] adc_data;
  logic        adc_valid;
  logic [16:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [15:0] ovf_cnt;

  int n_vec = 0;
  int n_err = 0;
  int n_cmpt = 0;
  int n_vcyc = 0;
  logic [16:0] q_word[$];
  logic        q_last[$];

  always #4 clk125 = ~clk125;

  tc_pl_cap_data u_dut (
    .clk125     (clk125),
    .rst_n      (rst_n),
    .data_en    (data_en),
    .data_cmpt  (data_cmpt),
    .gain_value (gain_value),
    .sample_len (sample_len),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .ovf_cnt    (ovf_cnt)
  );

  // Inputs change 1 time unit after posedge, so negedge sees what the next edge will.
  always @(negedge clk125) begin
    if (out_valid && out_ready) begin
      q_word.push_back(out_data);
      q_last.push_back(out_last);
    end
    if (data_cmpt) n_cmpt++;
    if (out_valid) n_vcyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk125);
    #1;
  endtask

  task automatic clr();
    q_word.delete();
    q_last.delete();
    n_cmpt = 0;
    n_vcyc = 0;
  endtask

  task automatic start(input logic [0:0] g, input logic [15:0] slen);
    gain_value = g;
    sample_len = slen;
    data_en    = 1'b1;
    tick();
  endtask

  task automatic feed(input int n, input logic [15:0] base, input bit gap);
    for (int i = 0; i < n; i++) begin
      adc_valid = 1'b1;
      adc_data  = base + 16'(i);
      tick();
      if (gap) begin
        adc_valid = 1'b0;
        adc_data  = 16'hDEAD;
        tick();
      end
    end
    adc_valid = 1'b0;
  endtask

  task automatic wait_cmpt(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (n_cmpt != 0) seen = 1'b1;
    end
    chk({tag, "_cmpt_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (out_valid) seen = 1'b1;
      else tick();
    end
    chk({tag, "_valid_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic check_seg(input string tag, input int n, input logic [16:0] first);
    int n_lasts = 0;
    chk({tag, "_count"}, 32'(q_word.size()), 32'(n));
    if (q_word.size() == n) begin
      for (int i = 0; i < n; i++) begin
        chk($sformatf("%s_w%0d", tag, i), 32'(q_word[i]), 32'(first + 17'(i)));
        if (q_last[i]) n_lasts++;
      end
      chk({tag, "_last_pos"}, 32'(q_last[n-1]), 32'd1);
    end
    chk({tag, "_last_cnt"}, 32'(n_lasts), (n > 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; data_en = 1'b0; gain_value = '0; sample_len = '0;
    adc_data = '0; adc_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_last",  32'(out_last),  32'd0);
    chk("rst_cmpt",  32'(data_cmpt), 32'd0);
    chk("rst_ovf",   32'(ovf_cnt),   32'd0);
    rst_n = 1'b1;
    tick();

    // len 4, gain 1, continuous samples; data_en then held high
    clr();
    start(1'b1, 16'd4);
    feed(4, 16'h0011, 1'b0);
    wait_cmpt("t1", 40);
    repeat (6) tick();
    check_seg("t1", 4, 17'h10011);
    chk("t1_cmpt_once", 32'(n_cmpt), 32'd1);
    data_en = 1'b0;
    repeat (2) tick();

    // len 8, adc_valid toggling
    clr();
    start(1'b0, 16'd8);
    feed(8, 16'h0100, 1'b1);
    wait_cmpt("t2", 40);
    check_seg("t2", 8, 17'h00100);
    data_en = 1'b0;
    repeat (2) tick();

    // back-pressure for 3 cycles on word 2
    clr();
    out_ready = 1'b0;
    start(1'b1, 16'd4);
    feed(4, 16'h00A0, 1'b0);
    wait_valid("t3", 10);
    chk("t3_w1_pre", 32'(out_data), 32'h100A0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t3_hold_data%0d", i), 32'(out_data), 32'h100A1);
      chk($sformatf("t3_hold_vld%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("t3_hold_last%0d", i), 32'(out_last), 32'd0);
      tick();
    end
    chk("t3_no_early_cmpt", 32'(n_cmpt), 32'd0);
    out_ready = 1'b1;
    wait_cmpt("t3", 20);
    check_seg("t3", 4, 17'h100A0);
    data_en = 1'b0;
    repeat (2) tick();

    // oversize request is clamped to the buffer depth
    clr();
    start(1'b1, 16'd2000);
    feed(1024, 16'h0000, 1'b0);
    wait_cmpt("t4", 1200);
    check_seg("t4", 1024, 17'h10000);
    chk("t4_ovf", 32'(ovf_cnt), 32'd1);
    data_en = 1'b0;
    repeat (2) tick();

    // abort on the 3rd capture cycle, then a clean segment
    clr();
    start(1'b0, 16'd4);
    feed(2, 16'h0050, 1'b0);
    data_en = 1'b0;
    adc_valid = 1'b1;
    adc_data = 16'h0052;
    tick();
    adc_valid = 1'b0;
    repeat (8) tick();
    chk("t5_abort_vcyc", 32'(n_vcyc), 32'd0);
    chk("t5_abort_cmpt", 32'(n_cmpt), 32'd0);
    clr();
    start(1'b1, 16'd2);
    feed(2, 16'h0070, 1'b0);
    wait_cmpt("t5", 20);
    check_seg("t5", 2, 17'h10070);
    data_en = 1'b0;
    repeat (2) tick();

    // zero-length segment
    clr();
    gain_value = 1'b1;
    sample_len = 16'd0;
    data_en = 1'b1;
    tick();
    chk("t6_cmpt_hi", 32'(data_cmpt), 32'd1);
    tick();
    chk("t6_cmpt_lo", 32'(data_cmpt), 32'd0);
    repeat (3) tick();
    chk("t6_words", 32'(q_word.size()), 32'd0);
    chk("t6_cmpt_once", 32'(n_cmpt), 32'd1);
    chk("t6_ovf_keep", 32'(ovf_cnt), 32'd1);
    data_en = 1'b0;
    repeat (2) tick();

    // reset while draining
    clr();
    out_ready = 1'b0;
    start(1'b1, 16'd4);
    feed(4, 16'h0030, 1'b0);
    wait_valid("t7", 10);
    rst_n = 1'b0;
    tick();
    chk("t7_valid", 32'(out_valid), 32'd0);
    chk("t7_data",  32'(out_data),  32'd0);
    chk("t7_last",  32'(out_last),  32'd0);
    chk("t7_cmpt",  32'(data_cmpt), 32'd0);
    chk("t7_ovf",   32'(ovf_cnt),   32'd0);
    rst_n = 1'b1;
    data_en = 1'b0;
    out_ready = 1'b1;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
